// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared opcodes, state encoding and access-size helpers for the memory stage
package mem_pkg;

   localparam int MEM_OP_W = 5;

   localparam logic [MEM_OP_W-1:0] MEM_NOP = 5'd0;
   localparam logic [MEM_OP_W-1:0] MEM_LB  = 5'd1;
   localparam logic [MEM_OP_W-1:0] MEM_LH  = 5'd2;
   localparam logic [MEM_OP_W-1:0] MEM_LW  = 5'd3;
   localparam logic [MEM_OP_W-1:0] MEM_LBU = 5'd4;
   localparam logic [MEM_OP_W-1:0] MEM_LHU = 5'd5;
   localparam logic [MEM_OP_W-1:0] MEM_SB  = 5'd6;
   localparam logic [MEM_OP_W-1:0] MEM_SH  = 5'd7;
   localparam logic [MEM_OP_W-1:0] MEM_SW  = 5'd8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } mem_state_e;

   function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
      return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
             (op == MEM_LBU) || (op == MEM_LHU);
   endfunction

   function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
      return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
   endfunction

   // Byte count of the access; 0 marks anything that bypasses memory.
   function automatic logic [2:0] mem_nbytes(input logic [MEM_OP_W-1:0] op);
      logic [2:0] n;
      n = 3'd0;
      if ((op == MEM_LB) || (op == MEM_LBU) || (op == MEM_SB)) n = 3'd1;
      if ((op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH)) n = 3'd2;
      if ((op == MEM_LW) || (op == MEM_SW))                    n = 3'd4;
      return n;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX/MEM input, memory-controller and writeback bundle; MEM_STAGE_FWD_EN adds the forward port
interface mem_stage_if
   import mem_pkg::*;
#(
   parameter int OP_W   = MEM_OP_W,
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
);
   logic              in_valid;
   logic [OP_W-1:0]   in_aluop;
   logic [ADDR_W-1:0] in_mem_addr;
   logic [XLEN-1:0]   in_data;
   logic [4:0]        in_rd_addr;
   logic              in_rd_en;
   logic              stall_req;
   logic              mc_req;
   logic              mc_we;
   logic [ADDR_W-1:0] mc_addr;
   logic [7:0]        mc_wdata;
   logic [7:0]        mc_rdata;
   logic              mc_ack;
   logic              wb_valid;
   logic [4:0]        wb_rd_addr;
   logic              wb_rd_en;
   logic [XLEN-1:0]   wb_data;

`ifdef MEM_STAGE_FWD_EN
   logic              fwd_valid;
   logic [4:0]        fwd_rd_addr;
   logic [XLEN-1:0]   fwd_data;

   modport slave (
      input  in_valid, in_aluop, in_mem_addr, in_data, in_rd_addr, in_rd_en,
      input  mc_rdata, mc_ack,
      output stall_req, mc_req, mc_we, mc_addr, mc_wdata,
      output wb_valid, wb_rd_addr, wb_rd_en, wb_data,
      output fwd_valid, fwd_rd_addr, fwd_data
   );

   modport master (
      output in_valid, in_aluop, in_mem_addr, in_data, in_rd_addr, in_rd_en,
      output mc_rdata, mc_ack,
      input  stall_req, mc_req, mc_we, mc_addr, mc_wdata,
      input  wb_valid, wb_rd_addr, wb_rd_en, wb_data,
      input  fwd_valid, fwd_rd_addr, fwd_data
   );
`else
   modport slave (
      input  in_valid, in_aluop, in_mem_addr, in_data, in_rd_addr, in_rd_en,
      input  mc_rdata, mc_ack,
      output stall_req, mc_req, mc_we, mc_addr, mc_wdata,
      output wb_valid, wb_rd_addr, wb_rd_en, wb_data
   );

   modport master (
      output in_valid, in_aluop, in_mem_addr, in_data, in_rd_addr, in_rd_en,
      output mc_rdata, mc_ack,
      input  stall_req, mc_req, mc_we, mc_addr, mc_wdata,
      input  wb_valid, wb_rd_addr, wb_rd_en, wb_data
   );
`endif

endinterface

// File: rtl/mem_ld_ext.sv
// rtl/mem_ld_ext.sv - combinational load extension: raw little-endian word + opcode to register value
module mem_ld_ext
   import mem_pkg::*;
(
   input  logic [31:0]         raw_i,
   input  logic [MEM_OP_W-1:0] op_i,
   output logic [31:0]         data_o
);

   always_comb begin
      data_o = raw_i;
      case (op_i)
         MEM_LB:  data_o = {{24{raw_i[7]}}, raw_i[7:0]};
         MEM_LBU: data_o = {24'd0, raw_i[7:0]};
         MEM_LH:  data_o = {{16{raw_i[15]}}, raw_i[15:0]};
         MEM_LHU: data_o = {16'd0, raw_i[15:0]};
         default: data_o = raw_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage with byte-serial loads/stores; MEM_STAGE_FWD_EN enables the decode bypass port
module mem_stage
   import mem_pkg::*;
#(
   parameter int OP_W   = MEM_OP_W,
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input logic        clk,
   input logic        rst,
   mem_stage_if.slave bus
);

   mem_state_e        state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [XLEN-1:0]   data_q, data_d;
   logic [4:0]        rd_addr_q, rd_addr_d;
   logic              rd_en_q, rd_en_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [31:0]       asm_q, asm_d;
   logic              mc_req_q, mc_req_d;
   logic              mc_we_q, mc_we_d;
   logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
   logic [7:0]        mc_wdata_q, mc_wdata_d;
   logic              wb_valid_q, wb_valid_d;
   logic [4:0]        wb_rd_addr_q, wb_rd_addr_d;
   logic              wb_rd_en_q, wb_rd_en_d;
   logic [XLEN-1:0]   wb_data_q, wb_data_d;

   logic [31:0]       asm_merged;
   logic [31:0]       ld_val;
   logic [1:0]        cnt_nx;
   logic              last_byte;

   // Assembly word with the byte arriving this cycle already dropped in.
   always_comb begin
      asm_merged = asm_q;
      asm_merged[{cnt_q, 3'b000} +: 8] = bus.mc_rdata;
   end

   assign cnt_nx    = cnt_q + 2'd1;
   assign last_byte = ({1'b0, cnt_q} == (mem_nbytes(op_q) - 3'd1));

   mem_ld_ext u_ld_ext (
      .raw_i  (asm_merged),
      .op_i   (op_q),
      .data_o (ld_val)
   );

   assign bus.stall_req = ((state_q == IDLE) && bus.in_valid && (mem_nbytes(bus.in_aluop) != 3'd0))
                        || (state_q == XFER);

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      data_d       = data_q;
      rd_addr_d    = rd_addr_q;
      rd_en_d      = rd_en_q;
      cnt_d        = cnt_q;
      asm_d        = asm_q;
      mc_req_d     = mc_req_q;
      mc_we_d      = mc_we_q;
      mc_addr_d    = mc_addr_q;
      mc_wdata_d   = mc_wdata_q;
      wb_valid_d   = 1'b0;
      wb_rd_addr_d = wb_rd_addr_q;
      wb_rd_en_d   = wb_rd_en_q;
      wb_data_d    = wb_data_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               if (mem_nbytes(bus.in_aluop) != 3'd0) begin
                  op_d       = bus.in_aluop;
                  data_d     = bus.in_data;
                  rd_addr_d  = bus.in_rd_addr;
                  rd_en_d    = bus.in_rd_en;
                  cnt_d      = 2'd0;
                  asm_d      = 32'd0;
                  mc_req_d   = 1'b1;
                  mc_we_d    = is_store(bus.in_aluop);
                  mc_addr_d  = bus.in_mem_addr;
                  mc_wdata_d = bus.in_data[7:0];
                  state_d    = XFER;
               end else begin
                  wb_valid_d   = 1'b1;
                  wb_data_d    = bus.in_data;
                  wb_rd_addr_d = bus.in_rd_addr;
                  wb_rd_en_d   = bus.in_rd_en && (bus.in_rd_addr != 5'd0);
               end
            end
         end
         XFER: begin
            if (bus.mc_ack && mc_req_q) begin
               if (last_byte) begin
                  mc_req_d     = 1'b0;
                  state_d      = DONE;
                  wb_valid_d   = 1'b1;
                  wb_rd_addr_d = rd_addr_q;
                  wb_rd_en_d   = is_load(op_q) && rd_en_q && (rd_addr_q != 5'd0);
                  wb_data_d    = is_load(op_q) ? XLEN'(ld_val) : '0;
               end else begin
                  asm_d      = asm_merged;
                  cnt_d      = cnt_nx;
                  mc_addr_d  = mc_addr_q + ADDR_W'(1);
                  mc_wdata_d = data_q[{cnt_nx, 3'b000} +: 8];
               end
            end
         end
         DONE: begin
            // The bundle still held upstream is the op just finished.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         op_q         <= '0;
         data_q       <= '0;
         rd_addr_q    <= '0;
         rd_en_q      <= 1'b0;
         cnt_q        <= '0;
         asm_q        <= '0;
         mc_req_q     <= 1'b0;
         mc_we_q      <= 1'b0;
         mc_addr_q    <= '0;
         mc_wdata_q   <= '0;
         wb_valid_q   <= 1'b0;
         wb_rd_addr_q <= '0;
         wb_rd_en_q   <= 1'b0;
         wb_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         data_q       <= data_d;
         rd_addr_q    <= rd_addr_d;
         rd_en_q      <= rd_en_d;
         cnt_q        <= cnt_d;
         asm_q        <= asm_d;
         mc_req_q     <= mc_req_d;
         mc_we_q      <= mc_we_d;
         mc_addr_q    <= mc_addr_d;
         mc_wdata_q   <= mc_wdata_d;
         wb_valid_q   <= wb_valid_d;
         wb_rd_addr_q <= wb_rd_addr_d;
         wb_rd_en_q   <= wb_rd_en_d;
         wb_data_q    <= wb_data_d;
      end
   end

   assign bus.mc_req     = mc_req_q;
   assign bus.mc_we      = mc_we_q;
   assign bus.mc_addr    = mc_addr_q;
   assign bus.mc_wdata   = mc_wdata_q;
   assign bus.wb_valid   = wb_valid_q;
   assign bus.wb_rd_addr = wb_rd_addr_q;
   assign bus.wb_rd_en   = wb_rd_en_q;
   assign bus.wb_data    = wb_data_q;

`ifdef MEM_STAGE_FWD_EN
   assign bus.fwd_valid   = wb_valid_q && wb_rd_en_q;
   assign bus.fwd_rd_addr = wb_rd_addr_q;
   assign bus.fwd_data    = wb_data_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed table-driven bench for mem_stage
module tb_mem_stage;
   import mem_pkg::*;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        rd_en;
      logic [31:0] rbytes;
      int          delay;
      int          n;
      logic        st;
      logic        chk_data;
      logic [31:0] exp_data;
      logic        exp_rden;
   } vec_t;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   mem_stage_if bus ();

   mem_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else n_pass++;
   endtask

   function automatic vec_t mk(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] data,
                               input logic [4:0] rd, input logic rd_en, input logic [31:0] rbytes,
                               input int delay, input int n, input logic st, input logic chk_data,
                               input logic [31:0] exp_data, input logic exp_rden);
      vec_t v;
      v.op = op; v.addr = addr; v.data = data; v.rd = rd; v.rd_en = rd_en;
      v.rbytes = rbytes; v.delay = delay; v.n = n; v.st = st;
      v.chk_data = chk_data; v.exp_data = exp_data; v.exp_rden = exp_rden;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input string nm);
      int  i, w, cyc, stalls, exp_lat;
      bit  done;
      i = 0; w = 0; cyc = 0; stalls = 0; done = 0;
      bus.in_valid    = 1'b1;
      bus.in_aluop    = v.op;
      bus.in_mem_addr = v.addr;
      bus.in_data     = v.data;
      bus.in_rd_addr  = v.rd;
      bus.in_rd_en    = v.rd_en;
      bus.mc_ack      = 1'b0;
      #1;
      while (!done && cyc < 200) begin
         if (bus.wb_valid) begin
            done = 1;
         end else begin
            stalls += int'(bus.stall_req);
            if (bus.mc_req) begin
               chk({nm, " mc_addr"}, bus.mc_addr, v.addr + 32'(i));
               chk({nm, " mc_we"}, 32'(bus.mc_we), 32'(v.st));
               if (v.st) chk({nm, " mc_wdata"}, 32'(bus.mc_wdata), 32'(v.data[8*i +: 8]));
               if (w == v.delay) begin
                  bus.mc_ack   = 1'b1;
                  bus.mc_rdata = v.rbytes[8*i +: 8];
                  i++;
                  w = 0;
               end else begin
                  bus.mc_ack = 1'b0;
                  w++;
               end
            end else begin
               bus.mc_ack = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (v.n == 0) bus.in_valid = 1'b0;
         end
      end
      bus.mc_ack = 1'b0;
      exp_lat = (v.n == 0) ? 1 : 1 + v.n * (v.delay + 1);
      chk({nm, " completed"}, 32'(done), 32'd1);
      chk({nm, " latency"}, 32'(cyc), 32'(exp_lat));
      chk({nm, " stall cycles"}, 32'(stalls), 32'((v.n == 0) ? 0 : exp_lat));
      chk({nm, " bytes"}, 32'(i), 32'(v.n));
      chk({nm, " stall in wb"}, 32'(bus.stall_req), 32'd0);
      chk({nm, " mc_req in wb"}, 32'(bus.mc_req), 32'd0);
      chk({nm, " wb_rd_addr"}, 32'(bus.wb_rd_addr), 32'(v.rd));
      chk({nm, " wb_rd_en"}, 32'(bus.wb_rd_en), 32'(v.exp_rden));
      if (v.chk_data) chk({nm, " wb_data"}, bus.wb_data, v.exp_data);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      #1;
      chk({nm, " wb pulse"}, 32'(bus.wb_valid), 32'd0);
      chk({nm, " no restart"}, 32'(bus.mc_req), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[13];
      vec_t vx;
      n_pass  = 0;
      n_total = 0;

      vecs[0]  = mk(MEM_NOP, 32'h0,        32'h12345678, 5'd5,  1'b1, 32'h0,        0, 0, 1'b0, 1'b1, 32'h12345678, 1'b1);
      vecs[1]  = mk(MEM_LW,  32'h1000,     32'h0,        5'd6,  1'b1, 32'h12345678, 0, 4, 1'b0, 1'b1, 32'h12345678, 1'b1);
      vecs[2]  = mk(MEM_LB,  32'h2001,     32'h0,        5'd7,  1'b1, 32'h00000080, 0, 1, 1'b0, 1'b1, 32'hFFFFFF80, 1'b1);
      vecs[3]  = mk(MEM_LBU, 32'h2001,     32'h0,        5'd8,  1'b1, 32'h00000080, 1, 1, 1'b0, 1'b1, 32'h00000080, 1'b1);
      vecs[4]  = mk(MEM_LH,  32'h3000,     32'h0,        5'd9,  1'b1, 32'h00008000, 0, 2, 1'b0, 1'b1, 32'hFFFF8000, 1'b1);
      vecs[5]  = mk(MEM_LHU, 32'h3002,     32'h0,        5'd10, 1'b1, 32'h00008000, 2, 2, 1'b0, 1'b1, 32'h00008000, 1'b1);
      vecs[6]  = mk(MEM_SH,  32'hFFFFFFFF, 32'hAABBCCDD, 5'd11, 1'b1, 32'h0,        3, 2, 1'b1, 1'b0, 32'h0,        1'b0);
      vecs[7]  = mk(MEM_SW,  32'h10,       32'h01020304, 5'd12, 1'b1, 32'h0,        1, 4, 1'b1, 1'b0, 32'h0,        1'b0);
      vecs[8]  = mk(MEM_SB,  32'h7,        32'h000000A5, 5'd13, 1'b0, 32'h0,        0, 1, 1'b1, 1'b0, 32'h0,        1'b0);
      vecs[9]  = mk(MEM_LW,  32'h1003,     32'h0,        5'd14, 1'b1, 32'hCAFEBABE, 0, 4, 1'b0, 1'b1, 32'hCAFEBABE, 1'b1);
      vecs[10] = mk(MEM_NOP, 32'h0,        32'hDEADBEEF, 5'd0,  1'b1, 32'h0,        0, 0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
      vecs[11] = mk(MEM_NOP, 32'h0,        32'h55AA55AA, 5'd3,  1'b0, 32'h0,        0, 0, 1'b0, 1'b1, 32'h55AA55AA, 1'b0);
      vecs[12] = mk(MEM_LB,  32'h40,       32'h0,        5'd15, 1'b1, 32'h0000007F, 0, 1, 1'b0, 1'b1, 32'h0000007F, 1'b1);

      rst = 1'b0;
      bus.in_valid = 1'b0; bus.in_aluop = MEM_NOP; bus.in_mem_addr = '0; bus.in_data = '0;
      bus.in_rd_addr = '0; bus.in_rd_en = 1'b0; bus.mc_rdata = '0; bus.mc_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset mc_req",     32'(bus.mc_req), 32'd0);
      chk("reset mc_we",      32'(bus.mc_we), 32'd0);
      chk("reset mc_addr",    bus.mc_addr, 32'd0);
      chk("reset mc_wdata",   32'(bus.mc_wdata), 32'd0);
      chk("reset wb_valid",   32'(bus.wb_valid), 32'd0);
      chk("reset wb_rd_addr", 32'(bus.wb_rd_addr), 32'd0);
      chk("reset wb_rd_en",   32'(bus.wb_rd_en), 32'd0);
      chk("reset wb_data",    bus.wb_data, 32'd0);
      chk("reset stall_req",  32'(bus.stall_req), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < 13; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

      // Reset while the third byte of a word load is outstanding.
      bus.in_valid = 1'b1; bus.in_aluop = MEM_LW; bus.in_mem_addr = 32'h500;
      bus.in_data = '0; bus.in_rd_addr = 5'd4; bus.in_rd_en = 1'b1;
      #1;
      @(posedge clk); #1;
      bus.mc_ack = 1'b1; bus.mc_rdata = 8'h11;
      @(posedge clk); #1;
      bus.mc_rdata = 8'h22;
      @(posedge clk); #1;
      chk("rst seq byte2 addr", bus.mc_addr, 32'h502);
      chk("rst seq byte2 req", 32'(bus.mc_req), 32'd1);
      bus.mc_ack = 1'b0; bus.in_valid = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      chk("rst seq mc_req", 32'(bus.mc_req), 32'd0);
      chk("rst seq idle", 32'(bus.stall_req), 32'd0);
      chk("rst seq wb_valid", 32'(bus.wb_valid), 32'd0);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("rst seq quiet wb", 32'(bus.wb_valid), 32'd0);
         chk("rst seq quiet req", 32'(bus.mc_req), 32'd0);
      end
      run_vec(mk(MEM_NOP, 32'h0, 32'h0BADF00D, 5'd2, 1'b1, 32'h0, 0, 0, 1'b0, 1'b1, 32'h0BADF00D, 1'b1), "post-reset nop");

      // Acks with no request outstanding must not disturb the stage.
      bus.mc_ack = 1'b1; bus.mc_rdata = 8'hEE;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("spurious ack mc_req", 32'(bus.mc_req), 32'd0);
         chk("spurious ack stall", 32'(bus.stall_req), 32'd0);
         chk("spurious ack wb", 32'(bus.wb_valid), 32'd0);
      end
      bus.mc_ack = 1'b0;
      vx = mk(MEM_LB, 32'h44, 32'h0, 5'd0, 1'b1, 32'h000000F0, 0, 1, 1'b0, 1'b1, 32'hFFFFFFF0, 1'b0);
      run_vec(vx, "x0 load");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
